// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS DIV/DIVU unit: bus widths,
// FSM state encodings, handshake levels and the ALU op codes that select it.
package div_unit_pkg;

   // Register bus widths used throughout the datapath.
   localparam int REG_BUS_W        = 32;
   localparam int DOUBLE_REG_BUS_W = 64;

   // Divider FSM states.
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Start request levels driven by EX.
   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   // Result-ready levels returned to EX.
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // ALU op codes that route an instruction to this unit.
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor and subtract when it fits.
// Purely combinational so narrow instances can be checked exhaustively.
module div_unit_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic         next_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0] shifted;

   // The partial remainder is always below the divisor, so after a subtract
   // the low W bits are the exact result and the extra bit only matters for
   // the comparison.
   always_comb begin
      shifted = {rem_in, next_bit};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider placed beside EX. Signed operands are converted
// to magnitudes on accept, 32 restoring steps run MSB first, and the signs
// are restored on the last step. Result is {remainder, quotient}.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   div_state_e        state;
   logic [DATA_W-1:0] dvd_q;
   logic [DATA_W-1:0] dsr;
   logic [DATA_W-1:0] rem;
   logic [CNT_W-1:0]  cnt;
   logic              sign_dvd;
   logic              sign_dsr;
   logic              signed_op;

   logic [DATA_W-1:0] step_rem;
   logic              step_q_bit;
   logic [DATA_W-1:0] quot_next;
   logic [DATA_W-1:0] quot_fixed;
   logic [DATA_W-1:0] rem_fixed;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   div_unit_step #(
      .W(DATA_W)
   ) u_step (
      .rem_in   (rem),
      .next_bit (dvd_q[DATA_W-1]),
      .divisor  (dsr),
      .rem_out  (step_rem),
      .q_bit    (step_q_bit)
   );

   // Dividend bits leave the top of dvd_q while quotient bits enter at the
   // bottom, so after the last step dvd_q holds the unsigned quotient; the
   // signed correction is applied to the final step's outputs.
   always_comb begin
      quot_next  = {dvd_q[DATA_W-2:0], step_q_bit};
      quot_fixed = cond_neg(quot_next, signed_op & (sign_dvd ^ sign_dsr));
      rem_fixed  = cond_neg(step_rem, signed_op & sign_dvd);
   end

   // Divider FSM and datapath; outputs change only when entering or leaving END.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DivFree;
         ready_o   <= DivResultNotReady;
         result_o  <= '0;
         cnt       <= '0;
         dvd_q     <= '0;
         dsr       <= '0;
         rem       <= '0;
         sign_dvd  <= 1'b0;
         sign_dsr  <= 1'b0;
         signed_op <= 1'b0;
      end else begin
         case (state)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DivByZero;
                  end else begin
                     state     <= DivOn;
                     cnt       <= '0;
                     rem       <= '0;
                     dvd_q     <= cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
                     dsr       <= cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
                     sign_dvd  <= signed_div_i & opdata1_i[DATA_W-1];
                     sign_dsr  <= signed_div_i & opdata2_i[DATA_W-1];
                     signed_op <= signed_div_i;
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  state    <= DivEnd;
                  result_o <= '0;
                  ready_o  <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
                  cnt   <= '0;
               end else begin
                  dvd_q <= quot_next;
                  rem   <= step_rem;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == LAST_STEP) begin
                     state    <= DivEnd;
                     result_o <= {rem_fixed, quot_fixed};
                     ready_o  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (annul_i || start_i == DivStop) begin
                  state    <= DivFree;
                  ready_o  <= DivResultNotReady;
                  result_o <= '0;
                  cnt      <= '0;
               end
            end
            default: begin
               state <= DivFree;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results are queued when a
// division is launched and compared when ready_o rises.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb_q[$];

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   // Reference: 64-bit arithmetic truncates toward zero and gives the
   // remainder the dividend's sign; divide by zero yields zero.
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   // Called just after a negedge: launches a division, scrambles the operands
   // after accept, checks latency and result, then the hold and clear.
   task automatic applyStimulus(input string tag, input logic sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] expv, input int expLat);
      int          lat;
      logic [63:0] want;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      sb_q.push_back(expv);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         opdata1_i = $urandom;
         opdata2_i = $urandom;
      end while (!ready_o && lat < 100);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
      want = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      checkOutput({tag, "_result"}, result_o, want);
      @(negedge clk);
      checkOutput({tag, "_hold"}, {result_o[62:0], ready_o}, {want[62:0], 1'b1});
      start_i = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_clear"}, {result_o[62:0], ready_o}, 64'd0);
   endtask

   // Counts cycles where outputs are not idle over a window.
   task automatic quietWindow(input string tag, input int n);
      int busy;
      busy = 0;
      for (int i = 0; i < n; i++) begin
         if (ready_o || result_o != 64'd0) busy++;
         @(negedge clk);
      end
      checkOutput(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      logic        sgn;
      logic [31:0] a, b;

      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 64'(ready_o), 64'd0);
      checkOutput("reset_result", result_o, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      applyStimulus("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33);
      applyStimulus("div_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
      applyStimulus("divu_by0", 1'b0, 32'h12345678, 32'h0, 64'd0, 2);
      applyStimulus("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
      applyStimulus("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 33);
      applyStimulus("div_by0", 1'b1, 32'h80000000, 32'h0, 64'd0, 2);

      // Annul during iteration at T+10 must kill the division.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      for (lat = 1; lat <= 10; lat++) @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      quietWindow("annul_quiet", 40);
      applyStimulus("after_annul", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33);

      // Synchronous reset at T+20 mid-division discards the work.
      signed_div_i = 1'b1;
      opdata1_i    = 32'hFFFF0000;
      opdata2_i    = 32'd17;
      start_i      = 1'b1;
      @(posedge clk);
      for (lat = 1; lat <= 20; lat++) @(negedge clk);
      rst     = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_outputs", {result_o[62:0], ready_o}, 64'd0);
      rst = 1'b0;
      quietWindow("rst_quiet", 40);

      // Annul while the result is held clears the outputs on the next edge.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd50;
      opdata2_i    = 32'd5;
      start_i      = 1'b1;
      sb_q.push_back(model(1'b0, 32'd50, 32'd5));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready_o && lat < 100);
      checkOutput("end_annul_result", result_o,
                  (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);
      annul_i = 1'b1;
      @(negedge clk);
      checkOutput("end_annul_clear", {result_o[62:0], ready_o}, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);

      // Back-to-back random divisions with a one-cycle gap between them.
      for (int i = 0; i < 8; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case (i % 4)
            0:       b = 32'($urandom_range(1, 15));
            1:       b = $urandom;
            2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            default: b = (i == 7) ? 32'd0 : 32'($urandom_range(1, 65535));
         endcase
         applyStimulus($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b),
                       (b == 32'd0) ? 2 : 33);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU, instantiated beside the EX stage.
- EX launches a division and holds the pipeline stalled until ready_o is high.
- EX then forwards result_o as {hi = remainder, lo = quotient} with whilo set into the EX/MEM register.
- A pipeline flush cancels an in-flight division through annul_i.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend; sampled only on accept
- opdata2_i  in  32  divisor; sampled only on accept
- start_i  in  1  request; EX holds it high until it sees ready_o
- annul_i  in  1  abort request or in-flight operation
- result_o  out  64  {remainder[31:0], quotient[31:0]}
- ready_o  out  1  result valid

Behaviour:
- Reset: state FREE, ready_o = 0, result_o = 0, counter = 0. Reset mid-operation discards all work.
- FSM states:
  - FREE (idle)
  - BY_ZERO
  - ON (iterating)
  - END (result held)
- FREE:
  - start_i & !annul_i & divisor == 0 -> BY_ZERO.
  - start_i & !annul_i & divisor != 0 -> ON. Latch the operands, counter = 0.
  - In signed mode, latch |dividend| and |divisor| and record both sign bits.
  - Any other input combination -> stay in FREE.
- BY_ZERO: -> END with result 0 next cycle. Fixed behaviour: quotient = 0, remainder = 0.
- ON, one restoring step per cycle, MSB first:
  - Partial remainder R (33-bit) = {R[31:0], next dividend bit}.
  - If R >= {0, divisor}: R -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter increments each cycle.
  - When the 32nd step completes (counter reaches 32), apply the sign fix and go to END.
- Sign fix (signed mode only):
  - Quotient is negated (two's complement) when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned mode: no fix.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0, wrapping with no trap. |0x80000000| is treated as unsigned 0x80000000.
- annul_i high in ON or BY_ZERO -> FREE next edge; ready_o never asserts and result_o stays 0.
- END:
  - ready_o = 1 and result_o is valid.
  - Stays in END while start_i = 1.
  - start_i = 0 -> FREE; the same edge clears ready_o and result_o to 0.
  - annul_i in END -> FREE, with outputs cleared.
- Latency, with the accept edge at the end of cycle T:
  - Nonzero divisor: ready_o high from cycle T+33.
  - Zero divisor: ready_o high from cycle T+2.
- Outputs are registered: ready_o and result_o are updated only on the edge that enters or leaves END. No combinational path from inputs to outputs.
- Operand changes after accept are ignored.
- start_i asserted while the unit is in ON does not restart the operation.
- Pipeline interaction: EX drives its stall request = start_i & !ready_o. While stall[3] holds EX/MEM, the EX/MEM register keeps its contents. The result is consumed in the cycle where ready_o = 1, and EX deasserts start_i on the following cycle.

Decomposition:
- Shared defines file holds:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2-bit).
  - DivStart / DivStop and DivResultReady / DivResultNotReady.
  - The DIV and DIVU ALU op codes.
- Reuse the existing RegBus and DoubleRegBus width macros.
- One natural sub-module: div_step. It is the combinational 33-bit compare/subtract/shift for a single iteration, kept separate so it can be unit-tested exhaustively on narrow widths.

Test Plan:
- DIVU 100 / 7:
  - start at T -> ready_o rises at T+33.
  - result_o = {0x00000002, 0x0000000E}.
  - ready_o stays high until start_i drops, then falls and result_o = 0.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, DIVU 0x12345678 / 0 -> ready_o at T+2, result_o = 0.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at cycle T+10 during ON -> state FREE at T+11. ready_o stays 0 for 40 cycles; a new start then completes correctly.
- rst asserted at T+20 mid-division -> all outputs 0 next edge. Operands changed after accept do not alter the result. Back-to-back divisions with start_i dropped for one cycle between them both return correct results.
